sqrt_core: RTL and testbench

Iterative radix-2 restoring square-root engine for the FPU sqrt path. It sits directly downstream of the sqrt input wrapper: it samples the wrapper's prepared radicand on the start_sqrt pulse and produces the integer root one bit per cycle. The downstream normalise/round stage consumes the root plus a sticky bit on the done pulse.

---
 rtl/sqrt_core.sv | 107 ++++++++++
 tb/tb_sqrt_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_core.sv
// Radix-2 restoring square-root engine: one root bit per cycle, registered root plus sticky.
// Accepts a 2*ROOT_W-bit radicand on start_sqrt and pulses done ROOT_W+1 cycles later.
module sqrt_core #(
  parameter int unsigned ROOT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_sqrt,
  input  logic [2*ROOT_W-1:0]   radicand,
  output logic [ROOT_W-1:0]     root,
  output logic                  sticky,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned CntW = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [ROOT_W+1:0]     rem_q, rem_d;
  logic [ROOT_W-1:0]     acc_q, acc_d;
  logic [2*ROOT_W-1:0]   rad_q, rad_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ROOT_W-1:0]     root_q, root_d;
  logic                  sticky_q, sticky_d;

  logic [ROOT_W+1:0]     rem_t;
  logic [ROOT_W+1:0]     trial;
  logic [ROOT_W+1:0]     rem_next;
  logic [ROOT_W-1:0]     acc_next;
  logic                  take;

  // Top two remainder bits are always zero before the shift; the remainder never exceeds 2*acc.
  logic unused_rem_top;
  assign unused_rem_top = ^rem_q[ROOT_W+1:ROOT_W];

  assign rem_t    = {rem_q[ROOT_W-1:0], rad_q[2*ROOT_W-1 -: 2]};
  assign trial    = {acc_q, 2'b01};
  assign take     = (rem_t >= trial);
  assign rem_next = take ? (rem_t - trial) : rem_t;
  assign acc_next = {acc_q[ROOT_W-2:0], take};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    rad_d    = rad_q;
    cnt_d    = cnt_q;
    root_d   = root_q;
    sticky_d = sticky_q;
    unique case (state_q)
      StIdle: begin
        if (start_sqrt) begin
          rad_d   = radicand;
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        rem_d = rem_next;
        acc_d = acc_next;
        rad_d = {rad_q[2*ROOT_W-3:0], 2'b00};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ROOT_W - 1)) begin
          root_d   = acc_next;
          sticky_d = (rem_next != '0);
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      acc_q    <= '0;
      rad_q    <= '0;
      cnt_q    <= '0;
      root_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      rad_q    <= rad_d;
      cnt_q    <= cnt_d;
      root_q   <= root_d;
      sticky_q <= sticky_d;
    end
  end

  assign root   = root_q;
  assign sticky = sticky_q;
  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_sqrt_core.sv
// Self-checking bench for sqrt_core: directed vectors, protocol corner cases and
// randomized operations against a floor(sqrt) reference computed with real arithmetic.
module tb_sqrt_core;

  localparam int unsigned RootW = 24;

  logic               clk;
  logic               rst;
  logic               start_sqrt;
  logic [2*RootW-1:0] radicand;
  logic [RootW-1:0]   root;
  logic               sticky;
  logic               done;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  sqrt_core #(.ROOT_W(RootW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_sqrt (start_sqrt),
    .radicand   (radicand),
    .root       (root),
    .sticky     (sticky),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [47:0] rad;
    logic [23:0] exp_root;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor(sqrt(x)) from double-precision sqrt, then corrected with exact integer squares.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Starts in the current cycle (call #1 after an edge, DUT idle); returns in cycle 26.
  task automatic do_op(input logic [47:0] rad, input string name,
                       input logic [23:0] er, input logic es);
    bit bad_window;
    bad_window = 1'b0;
    start_sqrt = 1'b1;
    radicand   = rad;
    step();
    start_sqrt = 1'b0;
    radicand   = 48'({$urandom, $urandom});
    start_cnt++;
    for (int c = 1; c <= 24; c++) begin
      if (done !== 1'b0 || busy !== 1'b1) bad_window = 1'b1;
      step();
    end
    check({name, " calc window"}, 64'(bad_window), 64'd0);
    check({name, " done@25"}, 64'(done), 64'd1);
    check({name, " root"}, 64'(root), 64'(er));
    check({name, " sticky"}, 64'(sticky), 64'(es));
    step();
    check({name, " done@26"}, 64'(done), 64'd0);
    check({name, " busy@26"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dones_before;
    int starts_before;
    int pulses;
    logic [47:0] r;

    vecs[0] = '{48'd0,                 24'd0,        1'b0};
    vecs[1] = '{48'd144,               24'd12,       1'b0};
    vecs[2] = '{48'h4000_0000_0000,    24'h800000,   1'b0};
    vecs[3] = '{48'h8000_0000_0000,    24'hB504F3,   1'b1};
    vecs[4] = '{48'hFFFF_FFFF_FFFF,    24'hFFFFFF,   1'b1};
    vecs[5] = '{48'd1,                 24'd1,        1'b0};
    vecs[6] = '{48'd2,                 24'd1,        1'b1};
    vecs[7] = '{48'd99,                24'd9,        1'b1};

    rst        = 1'b1;
    start_sqrt = 1'b0;
    radicand   = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle outputs", {root, sticky, done, busy}, 64'd0);
    end

    foreach (vecs[i]) begin
      do_op(vecs[i].rad, $sformatf("vec%0d", i), vecs[i].exp_root, vecs[i].exp_sticky);
    end

    // Starts while busy (mid-calc and in the done cycle) must be ignored.
    pulses = 0;
    start_sqrt = 1'b1;
    radicand   = 48'd144;
    step();
    start_sqrt = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 5 || c == 25) begin
        start_sqrt = 1'b1;
        radicand   = 48'h4000_0000_0000;
      end else begin
        start_sqrt = 1'b0;
      end
      if (done === 1'b1) pulses++;
      if (c == 25) begin
        check("busy prot root", 64'(root), 64'd12);
        check("busy prot sticky", 64'(sticky), 64'd0);
      end
      step();
    end
    start_sqrt = 1'b0;
    check("busy prot done pulses", 64'(pulses), 64'd1);
    check("busy prot idle@26", 64'(busy), 64'd0);
    start_cnt++;
    do_op(48'h4000_0000_0000, "after busy", 24'h800000, 1'b0);

    // Reset mid-operation: no done, outputs cleared, then a clean restart.
    do_op(48'hFFFF_FFFF_FFFF, "pre reset", 24'hFFFFFF, 1'b1);
    dones_before = done_cnt;
    start_sqrt = 1'b1;
    radicand   = 48'h8000_0000_0000;
    step();
    start_sqrt = 1'b0;
    for (int c = 1; c < 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset root", 64'(root), 64'd0);
    check("midreset sticky", 64'(sticky), 64'd0);
    for (int c = 0; c < 30; c++) step();
    check("midreset no done", 64'(done_cnt - dones_before), 64'd0);
    do_op(48'd144, "post reset", 24'd12, 1'b0);

    // Reset and start together: reset wins.
    rst        = 1'b1;
    start_sqrt = 1'b1;
    radicand   = 48'd144;
    step();
    rst        = 1'b0;
    start_sqrt = 1'b0;
    check("rst+start busy", 64'(busy), 64'd0);
    step();
    check("rst+start stays idle", 64'(busy), 64'd0);

    // Random back-to-back operations against the reference model.
    dones_before  = done_cnt;
    starts_before = start_cnt;
    for (int n = 0; n < 1000; n++) begin
      longint unsigned e;
      case ($urandom_range(3))
        0:       r = 48'($urandom_range(1000));
        1:       r = 48'($urandom) * 48'($urandom_range(65535));
        default: r = 48'({$urandom, $urandom});
      endcase
      e = isqrt(64'(r));
      do_op(r, $sformatf("rand%0d r=0x%0h", n, r), e[23:0], (e * e) != 64'(r));
    end
    check("rand done count", 64'(done_cnt - dones_before), 64'(start_cnt - starts_before));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
